// File: rtl/spi_txc_ctrl.sv
// Transmit-side SPI controller: serialises 8/16/32-bit frames on shift_out, optional trailing CRC frame.
// Optional feature macro: SPI_TXC_CRC_EN (CRC register, CRC frame and tx_crc_en).
module spi_txc_ctrl #(
    parameter int CNT_W = 13
) (
    input  logic             sclk_tx,
    input  logic             spi_tx_rstn,
    input  logic [31:0]      spi_tx_data,
    input  logic [1:0]       df,
    input  logic [CNT_W-1:0] spi_tnum_max,
    input  logic             lsbf,
    input  logic             crc_en,
    input  logic             rxonly,
    input  logic [31:0]      crc_poly,
    output logic [31:0]      tx_crc_data_out,
    output logic             tx_start,
    output logic             tx_num_max_en,
    output logic             tx_crc_en,
    output logic             shift_out
);

`ifdef SPI_TXC_CRC_EN
    localparam logic CRC_IMPL = 1'b1;
`else
    localparam logic CRC_IMPL = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       bit_q, bit_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       wcode_q, wcode_d;
    logic             lsbf_q, lsbf_d;
    logic [31:0]      poly_q, poly_d;
    logic [31:0]      crc_q, crc_d;
    logic             so_q, so_d;
    logic             start_q, start_d;
    logic             nmax_q, nmax_d;
    logic             crcen_q, crcen_d;

    function automatic logic [5:0] width_of(input logic [1:0] code);
        case (code)
            2'b01:   return 6'd16;
            2'b10:   return 6'd32;
            default: return 6'd8;
        endcase
    endfunction

    function automatic logic pick(input logic [31:0] v, input logic [5:0] n,
                                  input logic lsb, input logic [4:0] idx);
        logic [4:0] pos;
        pos = lsb ? idx : 5'(n - 6'd1 - {1'b0, idx});
        return v[pos];
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b,
                                             input logic [31:0] poly, input logic [5:0] n);
        logic [31:0] mask;
        logic        fb;
        mask = (n == 6'd32) ? '1 : ((32'h1 << n) - 32'h1);
        fb   = crc[5'(n - 6'd1)] ^ b;
        return ({crc[30:0], 1'b0} ^ (fb ? poly : '0)) & mask;
    endfunction

    logic [5:0]       n_cur, n_new;
    logic [CNT_W:0]   tmax_x, fnext;
    logic             load, nb;
    logic [CNT_W-1:0] load_frame;
    logic [4:0]       bnext;

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        data_d     = data_q;
        wcode_d    = wcode_q;
        lsbf_d     = lsbf_q;
        poly_d     = poly_q;
        crc_d      = crc_q;
        so_d       = 1'b0;
        start_d    = 1'b0;
        nmax_d     = 1'b0;
        crcen_d    = 1'b0;
        load       = 1'b0;
        load_frame = '0;
        nb         = 1'b0;
        n_cur      = width_of(wcode_q);
        n_new      = width_of(df);
        tmax_x     = (spi_tnum_max == '0) ? (CNT_W+1)'(1) : {1'b0, spi_tnum_max};
        fnext      = {1'b0, frame_q} + (CNT_W+1)'(1);
        bnext      = bit_q + 5'd1;

        case (state_q)
            S_IDLE: begin
                if (!rxonly) load = 1'b1;
            end
            S_DATA: begin
                if (rxonly) begin
                    state_d = S_DONE;
                end else if (bit_q != 5'(n_cur - 6'd1)) begin
                    bit_d  = bnext;
                    nb     = pick(data_q, n_cur, lsbf_q, bnext);
                    so_d   = nb;
                    nmax_d = nmax_q;
                    if (CRC_IMPL) crc_d = crc_step(crc_q, nb, poly_q, n_cur);
                end else if (fnext < tmax_x) begin
                    load       = 1'b1;
                    load_frame = fnext[CNT_W-1:0];
                end else if (CRC_IMPL && crc_en) begin
                    state_d = S_CRC;
                    bit_d   = '0;
                    so_d    = pick(crc_q, n_cur, lsbf_q, 5'd0);
                    crcen_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_CRC: begin
                if (rxonly || bit_q == 5'(n_cur - 6'd1)) begin
                    state_d = S_DONE;
                end else begin
                    bit_d   = bnext;
                    so_d    = pick(crc_q, n_cur, lsbf_q, bnext);
                    crcen_d = 1'b1;
                end
            end
            default: state_d = S_DONE;
        endcase

        // Frame load is shared by the IDLE start and the back-to-back reload; config is captured here.
        if (load) begin
            state_d = S_DATA;
            bit_d   = '0;
            frame_d = load_frame;
            data_d  = spi_tx_data;
            wcode_d = df;
            lsbf_d  = lsbf;
            poly_d  = crc_poly;
            nb      = pick(spi_tx_data, n_new, lsbf, 5'd0);
            so_d    = nb;
            start_d = 1'b1;
            nmax_d  = ({1'b0, load_frame} == tmax_x - (CNT_W+1)'(1));
            if (CRC_IMPL) crc_d = crc_step(crc_q, nb, crc_poly, n_new);
        end
    end

    always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
        if (!spi_tx_rstn) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            frame_q <= '0;
            data_q  <= '0;
            wcode_q <= '0;
            lsbf_q  <= 1'b0;
            poly_q  <= '0;
            crc_q   <= '0;
            so_q    <= 1'b0;
            start_q <= 1'b0;
            nmax_q  <= 1'b0;
            crcen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            wcode_q <= wcode_d;
            lsbf_q  <= lsbf_d;
            poly_q  <= poly_d;
            crc_q   <= crc_d;
            so_q    <= so_d;
            start_q <= start_d;
            nmax_q  <= nmax_d;
            crcen_q <= crcen_d;
        end
    end

    assign tx_crc_data_out = crc_q;
    assign tx_start        = start_q;
    assign tx_num_max_en   = nmax_q;
    assign tx_crc_en       = crcen_q;
    assign shift_out       = so_q;

endmodule

// File: tb/tb_spi_txc_ctrl.sv
// Scoreboard bench for spi_txc_ctrl: per-cycle expected outputs are queued at stimulus time and popped each cycle.
module tb_spi_txc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [1:0]  dfv;
    logic [12:0] tnum;
    logic        lsb, cen, rxo;
    logic [31:0] poly;
    logic [31:0] crc_out;
    logic        t_start, t_nmax, t_crc, so;

    spi_txc_ctrl #(.CNT_W(13)) dut (
        .sclk_tx(clk), .spi_tx_rstn(rst_n), .spi_tx_data(data), .df(dfv),
        .spi_tnum_max(tnum), .lsbf(lsb), .crc_en(cen), .rxonly(rxo), .crc_poly(poly),
        .tx_crc_data_out(crc_out), .tx_start(t_start), .tx_num_max_en(t_nmax),
        .tx_crc_en(t_crc), .shift_out(so)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        so;
        logic        st;
        logic        nm;
        logic        ce;
        logic        chk_crc;
        logic [31:0] crc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] so_hist;
    logic [31:0] last_crc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        n_tests++;
        if (obs !== ex) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, ex);
        end
    endtask

    function automatic logic [31:0] model_crc(input logic [31:0] c, input logic b,
                                              input logic [31:0] p, input int n);
        logic [31:0] mask;
        logic        fb;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        fb   = c[n-1] ^ b;
        c    = {c[30:0], 1'b0} ^ (fb ? p : 32'h0);
        return c & mask;
    endfunction

    task automatic push_idle(input int cycles, input logic chk, input logic [31:0] crcv);
        for (int i = 0; i < cycles; i++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, chk, crcv});
    endtask

    task automatic build();
        int          n, t, idx;
        logic [31:0] c;
        logic        b;
        n = (dfv == 2'b01) ? 16 : (dfv == 2'b10) ? 32 : 8;
        t = (tnum == 0) ? 1 : int'(tnum);
        c = 32'h0;
        for (int f = 0; f < t; f++)
            for (int i = 0; i < n; i++) begin
                idx = lsb ? i : n - 1 - i;
                b   = data[idx];
                c   = model_crc(c, b, poly, n);
                q.push_back('{b, i == 0, f == t - 1, 1'b0, 1'b0, 32'h0});
            end
`ifdef SPI_TXC_CRC_EN
        if (cen)
            for (int i = 0; i < n; i++) begin
                idx = lsb ? i : n - 1 - i;
                q.push_back('{c[idx], 1'b0, 1'b0, 1'b1, 1'b1, c});
            end
        last_crc = c;
`else
        last_crc = 32'h0;
`endif
        push_idle(3, 1'b1, last_crc);
    endtask

    task automatic run_expect(input string name);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            e       = q.pop_front();
            so_hist = {so_hist[62:0], so};
            check($sformatf("%s c%0d shift_out", name, cyc), {31'h0, so}, {31'h0, e.so});
            check($sformatf("%s c%0d tx_start", name, cyc), {31'h0, t_start}, {31'h0, e.st});
            check($sformatf("%s c%0d num_max_en", name, cyc), {31'h0, t_nmax}, {31'h0, e.nm});
            check($sformatf("%s c%0d crc_en", name, cyc), {31'h0, t_crc}, {31'h0, e.ce});
            if (e.chk_crc) check($sformatf("%s c%0d crc_out", name, cyc), crc_out, e.crc);
            cyc++;
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " shift_out"}, {31'h0, so}, 32'h0);
        check({name, " tx_start"}, {31'h0, t_start}, 32'h0);
        check({name, " num_max_en"}, {31'h0, t_nmax}, 32'h0);
        check({name, " crc_en"}, {31'h0, t_crc}, 32'h0);
        check({name, " crc_out"}, crc_out, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rxo   = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic transfer(input string name, input logic [31:0] d, input logic [1:0] w,
                            input logic [12:0] t, input logic l, input logic c, input logic [31:0] p);
        do_reset();
        data = d; dfv = w; tnum = t; lsb = l; cen = c; poly = p;
        so_hist = '0;
        build();
        rxo = 1'b0;
        run_expect(name);
    endtask

    initial begin
        rst_n = 1'b0; rxo = 1'b1; data = '0; dfv = '0; tnum = 13'd1;
        lsb = 1'b0; cen = 1'b0; poly = '0; so_hist = '0; last_crc = '0;

        transfer("t1_msb8", 32'h1234_5678, 2'b00, 13'd1, 1'b0, 1'b0, 32'h0);
        check("t1 pattern", {24'h0, so_hist[10:3]}, 32'h78);

        transfer("t2_lsb8", 32'h1234_5678, 2'b00, 13'd1, 1'b1, 1'b0, 32'h0);
        check("t2 pattern", {24'h0, so_hist[10:3]}, 32'h1E);

        transfer("t3_msb16x2", 32'hAABB_CCDD, 2'b01, 13'd2, 1'b0, 1'b0, 32'h0);
        check("t3 pattern", so_hist[34:3], 32'hCCDD_CCDD);

        transfer("t4_32b", 32'h55AA_55AA, 2'b10, 13'd1, 1'b0, 1'b0, 32'h0);
        check("t4 pattern", so_hist[34:3], 32'h55AA_55AA);

        transfer("t5_crc8", 32'h1234_5678, 2'b00, 13'd1, 1'b0, 1'b1, 32'h04C1_1DB7);
`ifdef SPI_TXC_CRC_EN
        check("t5 crc value", crc_out, 32'h66);
        check("t5 crc frame", {24'h0, so_hist[10:3]}, 32'h66);
`else
        check("t5 crc value off", crc_out, 32'h0);
`endif

        transfer("t_tnum0", 32'h0000_00A5, 2'b11, 13'd0, 1'b0, 1'b0, 32'h0);
        transfer("t_lsb32crc", 32'hDEAD_BEEF, 2'b10, 13'd3, 1'b1, 1'b1, 32'h04C1_1DB7);

        // rxonly held from reset keeps everything idle
        do_reset();
        data = 32'h1234_5678; dfv = 2'b00; tnum = 13'd1; lsb = 1'b0; cen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 check_zero($sformatf("rxonly c%0d", i));
        end

        // reset mid-frame, then restart from bit 0
        rxo = 1'b0;
        so_hist = '0;
        build();
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            e = q.pop_front();
            check($sformatf("pre-rst c%0d shift_out", i), {31'h0, so}, {31'h0, e.so});
        end
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        so_hist = '0;
        build();
        run_expect("restart");
        check("restart pattern", {24'h0, so_hist[10:3]}, 32'h78);

        // rxonly abort during DATA, then DONE must hold after rxonly drops
        do_reset();
        data = 32'hAABB_CCDD; dfv = 2'b01; tnum = 13'd2; lsb = 1'b0; cen = 1'b1; poly = 32'h1021;
        build();
        rxo = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            e = q.pop_front();
            check($sformatf("abort c%0d shift_out", i), {31'h0, so}, {31'h0, e.so});
        end
        q.delete();
        @(negedge clk);
        rxo = 1'b1;
        push_idle(4, 1'b0, 32'h0);
        run_expect("abort");
        @(negedge clk);
        rxo = 1'b0;
        push_idle(6, 1'b0, 32'h0);
        run_expect("done_hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
